avalon_bus_arbiter: RTL and testbench

Two-master, one-slave arbiter for the Avalon memory-mapped bus between `top_level_cpu` and `RAM`. Master 0 is the CPU bus port. Master 1 is a secondary requester, such as a program loader or DMA engine, that replaces the side-channel instruction-load port. The block grants the single RAM slave to one master at a time using round-robin priority and holds each grant until the transaction completes. It also flags transactions that stall past a timeout.

---
 rtl/avalon_bus_arbiter.sv | 150 +++++++++++++++
 tb/tb_avalon_bus_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/avalon_bus_arbiter.sv
// avalon_bus_arbiter
//   Two-master, one-slave Avalon-MM arbiter between the CPU bus port (M0)
//   and a secondary requester such as a loader/DMA engine (M1), in front of
//   a single RAM slave. Round-robin on simultaneous requests, grant held
//   until the slave completes the transfer, sticky flag on long stalls.
//
// Ports
//   clk, reset                  clock, synchronous active-low reset
//   m0_* / m1_*                 master ports: address, read, write,
//                               writedata, byteenable in; waitrequest,
//                               readdata out
//   s_*                         slave port: address, read, write,
//                               writedata, byteenable out; waitrequest,
//                               readdata in
//   grant                       one-hot owner (01 = M0, 10 = M1, 00 = idle)
//   stall_err                   sticky: TIMEOUT consecutive stalled cycles
module avalon_bus_arbiter #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] m0_address,
  input  logic        m0_read,
  input  logic        m0_write,
  input  logic [31:0] m0_writedata,
  input  logic [3:0]  m0_byteenable,
  output logic        m0_waitrequest,
  output logic [31:0] m0_readdata,
  input  logic [31:0] m1_address,
  input  logic        m1_read,
  input  logic        m1_write,
  input  logic [31:0] m1_writedata,
  input  logic [3:0]  m1_byteenable,
  output logic        m1_waitrequest,
  output logic [31:0] m1_readdata,
  output logic [31:0] s_address,
  output logic        s_read,
  output logic        s_write,
  output logic [31:0] s_writedata,
  output logic [3:0]  s_byteenable,
  input  logic        s_waitrequest,
  input  logic [31:0] s_readdata,
  output logic [1:0]  grant,
  output logic        stall_err
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic          last, last_nxt;      // 0 = M0 won the last tie, 1 = M1
  logic [CW-1:0] cnt, cnt_nxt;
  logic          err_q;

  logic req0, req1;
  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

  // Next state. The stall counter is zero whenever the next state is IDLE,
  // so clearing on every transition to IDLE falls out of the default.
  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    cnt_nxt   = '0;
    case (state)
      IDLE: begin
        if (req0 && req1) begin
          if (last) begin
            state_nxt = GNT0;
            last_nxt  = 1'b0;
          end else begin
            state_nxt = GNT1;
            last_nxt  = 1'b1;
          end
        end else if (req0) begin
          state_nxt = GNT0;
        end else if (req1) begin
          state_nxt = GNT1;
        end
      end
      GNT0: begin
        if (!req0 || !s_waitrequest) state_nxt = IDLE;
        else cnt_nxt = (cnt == CNT_MAX) ? cnt : cnt + CW'(1);
      end
      GNT1: begin
        if (!req1 || !s_waitrequest) state_nxt = IDLE;
        else cnt_nxt = (cnt == CNT_MAX) ? cnt : cnt + CW'(1);
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      last  <= 1'b1;
      cnt   <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
      cnt   <= cnt_nxt;
      err_q <= err_q | (cnt_nxt == CNT_MAX);
    end
  end

  // Slave command mux and master stalls.
  always_comb begin
    s_address      = '0;
    s_read         = 1'b0;
    s_write        = 1'b0;
    s_writedata    = '0;
    s_byteenable   = '0;
    m0_waitrequest = 1'b1;
    m1_waitrequest = 1'b1;
    grant          = 2'b00;
    case (state)
      GNT0: begin
        s_address      = m0_address;
        s_read         = m0_read;
        s_write        = m0_write;
        s_writedata    = m0_writedata;
        s_byteenable   = m0_byteenable;
        m0_waitrequest = s_waitrequest;
        grant          = 2'b01;
      end
      GNT1: begin
        s_address      = m1_address;
        s_read         = m1_read;
        s_write        = m1_write;
        s_writedata    = m1_writedata;
        s_byteenable   = m1_byteenable;
        m1_waitrequest = s_waitrequest;
        grant          = 2'b10;
      end
      default: ;
    endcase
  end

  assign m0_readdata = s_readdata;
  assign m1_readdata = s_readdata;
  assign stall_err   = err_q;

endmodule

// File: tb/tb_avalon_bus_arbiter.sv
// Self-checking bench for avalon_bus_arbiter (TIMEOUT = 8).
// Directed vector table, hand-written stall/reset sequences, then random
// traffic compared against a transaction-level reference model.
module tb_avalon_bus_arbiter;

  localparam int unsigned T = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] m0_address, m0_writedata, m0_readdata;
  logic        m0_read, m0_write, m0_waitrequest;
  logic [3:0]  m0_byteenable;
  logic [31:0] m1_address, m1_writedata, m1_readdata;
  logic        m1_read, m1_write, m1_waitrequest;
  logic [3:0]  m1_byteenable;
  logic [31:0] s_address, s_writedata, s_readdata;
  logic        s_read, s_write, s_waitrequest;
  logic [3:0]  s_byteenable;
  logic [1:0]  grant;
  logic        stall_err;

  always #5 clk = ~clk;

  avalon_bus_arbiter #(.TIMEOUT(T)) dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
    .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
    .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
    .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
    .s_address(s_address), .s_read(s_read), .s_write(s_write),
    .s_writedata(s_writedata), .s_byteenable(s_byteenable),
    .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
    .grant(grant), .stall_err(stall_err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: who owns the bus (-1 none), who won the last tie,
  // how many consecutive stalled granted cycles, sticky error.
  int   mo;
  int   ml;
  int   mc;
  logic me;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_check(input string tag);
    logic [31:0] ea, ed;
    logic [3:0]  eb;
    logic        er, ew;
    logic [1:0]  eg;
    ea = '0; ed = '0; eb = '0; er = 1'b0; ew = 1'b0; eg = 2'b00;
    if (mo == 0) begin
      ea = m0_address; ed = m0_writedata; eb = m0_byteenable;
      er = m0_read; ew = m0_write; eg = 2'b01;
    end else if (mo == 1) begin
      ea = m1_address; ed = m1_writedata; eb = m1_byteenable;
      er = m1_read; ew = m1_write; eg = 2'b10;
    end
    chk({tag, " grant"},   32'(grant), 32'(eg));
    chk({tag, " s_addr"},  s_address, ea);
    chk({tag, " s_wdata"}, s_writedata, ed);
    chk({tag, " s_be"},    32'(s_byteenable), 32'(eb));
    chk({tag, " s_cmd"},   32'({s_read, s_write}), 32'({er, ew}));
    chk({tag, " m0_wait"}, 32'(m0_waitrequest), (mo == 0) ? 32'(s_waitrequest) : 32'd1);
    chk({tag, " m1_wait"}, 32'(m1_waitrequest), (mo == 1) ? 32'(s_waitrequest) : 32'd1);
    chk({tag, " rdata"},   m0_readdata ^ m1_readdata ^ s_readdata, s_readdata);
    chk({tag, " err"},     32'(stall_err), 32'(me));
  endtask

  task automatic model_edge();
    logic r0, r1, rq;
    r0 = m0_read | m0_write;
    r1 = m1_read | m1_write;
    if (!reset) begin
      mo = -1; ml = 1; mc = 0; me = 1'b0;
    end else if (mo < 0) begin
      if (r0 && r1) begin
        mo = 1 - ml;
        ml = mo;
      end else if (r0) mo = 0;
      else if (r1) mo = 1;
    end else begin
      rq = (mo == 0) ? r0 : r1;
      if (!rq || !s_waitrequest) begin
        mo = -1;
        mc = 0;
      end else begin
        mc = (mc < int'(T)) ? mc + 1 : int'(T);
        if (mc == int'(T)) me = 1'b1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive(input logic r0, input logic w0, input logic r1,
                       input logic w1, input logic sw, input logic rst);
    m0_read = r0; m0_write = w0; m1_read = r1; m1_write = w1;
    s_waitrequest = sw; reset = rst;
  endtask

  typedef struct {
    logic        r0, w0, r1, w1, sw, rst;
    logic [1:0]  g;
    logic        wq0, wq1, sr, swr;
    logic [31:0] addr, wdata;
    logic [3:0]  be;
  } vec_t;

  vec_t tbl[19];

  initial begin
    // Fixed master payloads for the directed part.
    m0_address = 32'hBFC00000; m0_writedata = 32'h11112222; m0_byteenable = 4'hF;
    m1_address = 32'h00000010; m1_writedata = 32'hDEADBEEF; m1_byteenable = 4'b0011;
    s_readdata = 32'h24020010;
    //            r0 w0 r1 w1 sw rst  g     wq0 wq1 sr sw  addr           wdata          be
    tbl[0]  = '{0, 0, 0, 0, 0, 1, 2'b00, 1, 1, 0, 0, 32'h0,         32'h0,         4'h0};
    tbl[1]  = '{1, 0, 0, 0, 0, 1, 2'b00, 1, 1, 0, 0, 32'h0,         32'h0,         4'h0};
    tbl[2]  = '{1, 0, 0, 0, 0, 1, 2'b01, 0, 1, 1, 0, 32'hBFC00000,  32'h11112222,  4'hF};
    tbl[3]  = '{0, 0, 0, 0, 0, 1, 2'b00, 1, 1, 0, 0, 32'h0,         32'h0,         4'h0};
    tbl[4]  = '{1, 0, 0, 1, 0, 1, 2'b00, 1, 1, 0, 0, 32'h0,         32'h0,         4'h0};
    tbl[5]  = '{1, 0, 0, 1, 0, 1, 2'b01, 0, 1, 1, 0, 32'hBFC00000,  32'h11112222,  4'hF};
    tbl[6]  = '{1, 0, 0, 1, 0, 1, 2'b00, 1, 1, 0, 0, 32'h0,         32'h0,         4'h0};
    tbl[7]  = '{1, 0, 0, 1, 0, 1, 2'b10, 1, 0, 0, 1, 32'h00000010,  32'hDEADBEEF,  4'h3};
    tbl[8]  = '{1, 0, 0, 1, 0, 1, 2'b00, 1, 1, 0, 0, 32'h0,         32'h0,         4'h0};
    tbl[9]  = '{1, 0, 0, 1, 0, 1, 2'b01, 0, 1, 1, 0, 32'hBFC00000,  32'h11112222,  4'hF};
    tbl[10] = '{0, 0, 0, 0, 0, 1, 2'b00, 1, 1, 0, 0, 32'h0,         32'h0,         4'h0};
    tbl[11] = '{1, 0, 0, 0, 1, 1, 2'b00, 1, 1, 0, 0, 32'h0,         32'h0,         4'h0};
    tbl[12] = '{1, 0, 0, 1, 1, 1, 2'b01, 1, 1, 1, 0, 32'hBFC00000,  32'h11112222,  4'hF};
    tbl[13] = '{1, 0, 0, 1, 1, 1, 2'b01, 1, 1, 1, 0, 32'hBFC00000,  32'h11112222,  4'hF};
    tbl[14] = '{1, 0, 0, 1, 1, 1, 2'b01, 1, 1, 1, 0, 32'hBFC00000,  32'h11112222,  4'hF};
    tbl[15] = '{1, 0, 0, 1, 0, 1, 2'b01, 0, 1, 1, 0, 32'hBFC00000,  32'h11112222,  4'hF};
    tbl[16] = '{0, 0, 0, 1, 0, 1, 2'b00, 1, 1, 0, 0, 32'h0,         32'h0,         4'h0};
    tbl[17] = '{0, 0, 0, 1, 0, 1, 2'b10, 1, 0, 0, 1, 32'h00000010,  32'hDEADBEEF,  4'h3};
    tbl[18] = '{0, 0, 0, 0, 0, 1, 2'b00, 1, 1, 0, 0, 32'h0,         32'h0,         4'h0};

    mo = -1; ml = 1; mc = 0; me = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    tick();
    tick();

    // Directed vectors: single read, alternating ties, stalled grant.
    for (int i = 0; i < 19; i++) begin
      drive(tbl[i].r0, tbl[i].w0, tbl[i].r1, tbl[i].w1, tbl[i].sw, tbl[i].rst);
      #3;
      chk($sformatf("row%0d grant", i),  32'(grant), 32'(tbl[i].g));
      chk($sformatf("row%0d wait0", i),  32'(m0_waitrequest), 32'(tbl[i].wq0));
      chk($sformatf("row%0d wait1", i),  32'(m1_waitrequest), 32'(tbl[i].wq1));
      chk($sformatf("row%0d cmd", i),    32'({s_read, s_write}), 32'({tbl[i].sr, tbl[i].swr}));
      chk($sformatf("row%0d addr", i),   s_address, tbl[i].addr);
      chk($sformatf("row%0d wdata", i),  s_writedata, tbl[i].wdata);
      chk($sformatf("row%0d be", i),     32'(s_byteenable), 32'(tbl[i].be));
      chk($sformatf("row%0d rdata", i),  m0_readdata, 32'h24020010);
      chk($sformatf("row%0d err", i),    32'(stall_err), 32'd0);
      model_check($sformatf("row%0d", i));
      tick();
    end

    // Timeout: M0 stalled 12 cycles, flag after the 8th, grant kept.
    drive(1, 0, 0, 0, 1, 1);
    #3; chk("to idle grant", 32'(grant), 32'd0); model_check("to idle");
    tick();
    for (int i = 1; i <= 12; i++) begin
      #3;
      chk($sformatf("to g%0d grant", i), 32'(grant), 32'd1);
      chk($sformatf("to g%0d err", i), 32'(stall_err), (i >= 9) ? 32'd1 : 32'd0);
      model_check($sformatf("to g%0d", i));
      tick();
    end
    drive(1, 0, 0, 0, 0, 1);
    #3; chk("to done wait0", 32'(m0_waitrequest), 32'd0); model_check("to done");
    tick();
    drive(0, 0, 0, 0, 0, 1);
    #3; chk("to after grant", 32'(grant), 32'd0);
    chk("to sticky err", 32'(stall_err), 32'd1); model_check("to after");
    tick();

    // Reset during a stalled M1 write.
    drive(0, 0, 0, 1, 1, 1);
    #3; model_check("rst idle");
    tick();
    #3; chk("rst g1 grant", 32'(grant), 32'd2); model_check("rst g1");
    tick();
    reset = 1'b0;
    #3; chk("rst pre grant", 32'(grant), 32'd2); model_check("rst pre");
    tick();
    drive(1, 0, 0, 1, 0, 1);
    #3;
    chk("rst post grant", 32'(grant), 32'd0);
    chk("rst post s_write", 32'(s_write), 32'd0);
    chk("rst post err", 32'(stall_err), 32'd0);
    model_check("rst post");
    tick();
    #3; chk("rst tie grant", 32'(grant), 32'd1); model_check("rst tie");
    tick();

    // Random traffic against the reference model.
    for (int i = 0; i < 600; i++) begin
      m0_read = ($urandom_range(0, 2) == 0); m0_write = ($urandom_range(0, 2) == 0);
      m1_read = ($urandom_range(0, 2) == 0); m1_write = ($urandom_range(0, 2) == 0);
      m0_address = $urandom; m0_writedata = $urandom; m0_byteenable = 4'($urandom);
      m1_address = $urandom; m1_writedata = $urandom; m1_byteenable = 4'($urandom);
      s_readdata = $urandom;
      s_waitrequest = ($urandom_range(0, 9) < 8);
      reset = ($urandom_range(0, 79) != 0);
      #3;
      model_check($sformatf("rnd%0d", i));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
